slow_clk_period_meter: RTL and testbench



---
 rtl/slow_clk_period_meter.sv | 185 ++++++++++++++++++
 tb/tb_slow_clk_period_meter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_period_meter.sv
// Slow-clock receiver: synchronises a divider-generated clock into the fast
// domain, emits registered RISE/FALL ticks, measures period and high time in
// fast-clock cycles and raises a sticky flag when the slow clock stalls.
module slow_clk_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sin_i,
  input  logic             en_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             valid_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {
    StIdle,
    StSeekLow,
    StSeekRise,
    StMeasure,
    StStall
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  logic s1_q, s2_q, prev_q;
  logic rise_q, fall_q;
  logic rise_det, fall_det;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             hact_q, hact_d;
  logic [CNT_W-1:0] hlat_q, hlat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             at_limit;

  assign rise_det = s2_q & ~prev_q;
  assign fall_det = ~s2_q & prev_q;
  assign at_limit = (pcnt_q == CntLast);

  // Two-flop synchroniser, edge-history flop and registered edge ticks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= sin_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= rise_det;
      fall_q <= fall_det;
    end
  end

  // Measurement state, counters and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      hact_q    <= 1'b0;
      hlat_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      hact_q    <= hact_d;
      hlat_q    <= hlat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: EN low overrides everything and parks the FSM in idle.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    hact_d    = hact_q;
    hlat_d    = hlat_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!en_i) begin
      state_d   = StIdle;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pcnt_d  = CntZero;
          hact_d  = 1'b0;
          state_d = StSeekLow;
        end
        // Wait for a low level so a start-up rise is never half a period.
        StSeekLow: begin
          if (!s2_q) begin
            state_d = StSeekRise;
            pcnt_d  = CntZero;
          end else if (at_limit) begin
            timeout_d = 1'b1;
            state_d   = StStall;
          end else begin
            pcnt_d = pcnt_q + CntOne;
          end
        end
        StSeekRise: begin
          if (rise_det) begin
            state_d = StMeasure;
            pcnt_d  = CntOne;
            hcnt_d  = CntOne;
            hact_d  = 1'b1;
          end else if (at_limit) begin
            timeout_d = 1'b1;
            state_d   = StStall;
          end else begin
            pcnt_d = pcnt_q + CntOne;
          end
        end
        StMeasure: begin
          if (rise_det) begin
            period_d = pcnt_q;
            high_d   = hlat_q;
            valid_d  = 1'b1;
            pcnt_d   = CntOne;
            hcnt_d   = CntOne;
            hact_d   = 1'b1;
          end else begin
            if (at_limit) begin
              timeout_d = 1'b1;
              state_d   = StStall;
            end else begin
              pcnt_d = pcnt_q + CntOne;
            end
            if (fall_det) begin
              hlat_d = hcnt_q;
              hact_d = 1'b0;
            end else if (hact_q) begin
              hcnt_d = hcnt_q + CntOne;
            end
          end
        end
        // Frozen until the slow clock comes back; its first rise reopens a period.
        StStall: begin
          if (rise_det) begin
            state_d   = StMeasure;
            pcnt_d    = CntOne;
            hcnt_d    = CntOne;
            hact_d    = 1'b1;
            timeout_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign period_o    = period_q;
  assign high_time_o = high_q;
  assign valid_o     = valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_slow_clk_period_meter.sv
// Scoreboard bench: a timestamp-based reference model pushes expected edge
// ticks, measurements and timeout transitions; a monitor pops them as the
// DUT presents outputs.
module tb_slow_clk_period_meter;

  localparam int unsigned CNT_W = 16;
  localparam int          TO    = 4000;

  localparam int MIdle = 0, MWaitLow = 1, MWaitRise = 2, MMeasure = 3, MStall = 4;

  logic             clk = 1'b0;
  logic             rst, sin, en;
  logic             rise, fall, valid, timeout;
  logic [CNT_W-1:0] period, high_time;

  slow_clk_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sin_i      (sin),
    .en_i       (en),
    .rise_o     (rise),
    .fall_o     (fall),
    .period_o   (period),
    .high_time_o(high_time),
    .valid_o    (valid),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int t;
    int per;
    int hi;
  } meas_t;

  meas_t valid_q[$];
  int    rise_q[$];
  int    fall_q[$];
  int    tmo_q[$];

  // Reference model state: mode, timestamps, input history.
  int   m_mode, m_ref, m_rise_t, m_hlat;
  bit   m_tmo;
  logic h1, h2, h3;

  // Monitor-side state.
  logic last_tmo   = 1'b0;
  int   hold_per   = 0;
  int   hold_hi    = 0;
  int   first_rise = -1;
  int   n_valid    = 0;

  // Waveform generator.
  int wper = 1, whigh = 1, wpos = 0;
  bit wstop = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode = MIdle; m_ref = 0; m_rise_t = 0; m_hlat = 0; m_tmo = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    valid_q.delete(); rise_q.delete(); fall_q.delete(); tmo_q.delete();
  endfunction

  function automatic void set_tmo(input bit v, input int t);
    if (m_tmo != v) begin
      m_tmo = v;
      tmo_q.push_back(t);
    end
  endfunction

  // Called once per clock edge t with the inputs sampled at that edge.
  function automatic void model_edge(input logic s, input logic e, input int t);
    bit r, f;
    meas_t m;
    r = h2 & ~h3;
    f = ~h2 & h3;
    if (r) rise_q.push_back(t);
    if (f) fall_q.push_back(t);
    if (!e) begin
      m_mode = MIdle;
      set_tmo(1'b0, t);
    end else begin
      case (m_mode)
        MIdle: begin m_mode = MWaitLow; m_ref = t + 1; end
        MWaitLow: begin
          if (!h2) begin m_mode = MWaitRise; m_ref = t + 1; end
          else if (t - m_ref == TO - 1) begin m_mode = MStall; set_tmo(1'b1, t); end
        end
        MWaitRise: begin
          if (r) begin m_mode = MMeasure; m_rise_t = t; end
          else if (t - m_ref == TO - 1) begin m_mode = MStall; set_tmo(1'b1, t); end
        end
        MMeasure: begin
          if (r) begin
            m.t = t; m.per = t - m_rise_t; m.hi = m_hlat;
            valid_q.push_back(m);
            m_rise_t = t;
          end else begin
            if (f) m_hlat = t - m_rise_t;
            if (t - m_rise_t == TO - 1) begin m_mode = MStall; set_tmo(1'b1, t); end
          end
        end
        MStall: begin
          if (r) begin m_mode = MMeasure; m_rise_t = t; set_tmo(1'b0, t); end
        end
        default: m_mode = MIdle;
      endcase
    end
    h3 = h2; h2 = h1; h1 = s;
  endfunction

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    meas_t m;
    int    t;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("reset_outputs_zero",
            longint'(rise | fall | valid | timeout | (period != 0) | (high_time != 0)), 0);
        last_tmo = 1'b0; hold_per = 0; hold_hi = 0; first_rise = -1;
        continue;
      end
      if (rise) begin
        if (first_rise < 0) first_rise = cyc;
        if (rise_q.size() == 0) chk("rise_unexpected", 1, 0);
        else begin t = rise_q.pop_front(); chk("rise_cycle", cyc, t); end
      end
      while (rise_q.size() > 0 && rise_q[0] <= cyc) begin
        t = rise_q.pop_front(); chk("rise_missed", cyc, t + 1);
      end
      if (fall) begin
        if (fall_q.size() == 0) chk("fall_unexpected", 1, 0);
        else begin t = fall_q.pop_front(); chk("fall_cycle", cyc, t); end
      end
      while (fall_q.size() > 0 && fall_q[0] <= cyc) begin
        t = fall_q.pop_front(); chk("fall_missed", cyc, t + 1);
      end
      if (valid) begin
        n_valid++;
        if (valid_q.size() == 0) chk("valid_unexpected", 1, 0);
        else begin
          m = valid_q.pop_front();
          chk("valid_cycle", cyc, m.t);
          chk("period", period, m.per);
          chk("high_time", high_time, m.hi);
          hold_per = m.per; hold_hi = m.hi;
        end
      end else begin
        chk("period_hold", period, hold_per);
        chk("high_time_hold", high_time, hold_hi);
      end
      while (valid_q.size() > 0 && valid_q[0].t <= cyc) begin
        m = valid_q.pop_front(); chk("valid_missed", cyc, m.t + 1);
      end
      if (timeout !== last_tmo) begin
        if (tmo_q.size() == 0) chk("timeout_unexpected_change", timeout, last_tmo);
        else begin t = tmo_q.pop_front(); chk("timeout_cycle", cyc, t); end
        last_tmo = timeout;
      end
      while (tmo_q.size() > 0 && tmo_q[0] <= cyc) begin
        t = tmo_q.pop_front(); chk("timeout_missed", cyc, t + 1);
      end
    end
  end

  // One clock: drive SIN from the waveform at the falling edge, then run the model.
  task automatic step();
    sin = (!wstop && wpos < whigh);
    wpos = (wpos + 1) % wper;
    @(posedge clk);
    cyc++;
    if (!rst) model_edge(sin, en, cyc);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_wave(input int p, input int h);
    wper = p; whigh = h; wpos = 0; wstop = 1'b0;
  endtask

  task automatic align();
    while (wpos != 0) step();
  endtask

  // Release reset with SIN held high and check the first RISE latency.
  task automatic release_and_check_start();
    int rel;
    rst = 1'b0;
    rel = cyc + 1;
    steps(6);
    chk("first_rise_latency", first_rise, rel + 2);
  endtask

  initial begin
    int v0, p, h, n, drop;
    rst = 1'b1; sin = 1'b1; en = 1'b1;
    model_reset();
    set_wave(1, 1);
    @(negedge clk);
    steps(3);

    // Start-up with SIN high at release.
    release_and_check_start();
    set_wave(20, 10);
    steps(100);

    // Slow 1000-cycle clock, 50% duty.
    align();
    set_wave(1000, 500);
    steps(5200);
    chk("period_1000", period, 1000);
    chk("high_500", high_time, 500);

    // Fast clock, then a rate change at a period boundary.
    align();
    set_wave(7, 2);
    steps(70);
    chk("period_7", period, 7);
    chk("high_2", high_time, 2);
    align();
    set_wave(12, 9);
    steps(60);
    chk("period_12", period, 12);
    chk("high_9", high_time, 9);

    // Stall after a rise, then recover.
    align();
    set_wave(1000, 500);
    steps(2100);
    while (wpos != 600) step();
    wstop = 1'b1;
    v0 = n_valid;
    steps(4100);
    chk("timeout_raised", timeout, 1);
    chk("no_valid_while_stalled", n_valid - v0, 0);
    chk("period_held_in_stall", period, 1000);
    set_wave(1000, 500);
    steps(10);
    chk("timeout_cleared_on_rise", timeout, 0);
    steps(1100);
    chk("period_after_stall", period, 1000);

    // EN dropped mid-period.
    steps(300);
    en = 1'b0;
    steps(10);
    chk("en_low_timeout", timeout, 0);
    chk("en_low_period_held", period, 1000);
    en = 1'b1;
    steps(2200);

    // EN dropped on the very edge that produces rise_det.
    align();
    step();
    step();
    en = 1'b0;
    v0 = n_valid;
    steps(10);
    chk("en_drop_on_rise_no_valid", n_valid - v0, 0);
    en = 1'b1;
    steps(2200);
    chk("period_after_en_drop", period, 1000);

    // Random waveforms with random EN drops.
    drop = 0;
    for (int seg = 0; seg < 12; seg++) begin
      p = $urandom_range(80, 4);
      h = $urandom_range(p - 1, 1);
      set_wave(p, h);
      n = $urandom_range(400, 150);
      for (int i = 0; i < n; i++) begin
        if (drop == 0 && $urandom_range(199, 0) == 0) drop = $urandom_range(15, 1);
        en = (drop == 0);
        if (drop > 0) drop--;
        step();
      end
    end
    en = 1'b1;

    // Asynchronous reset in the middle of a measurement.
    set_wave(50, 20);
    steps(200);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_rise", rise, 0);
    chk("async_reset_fall", fall, 0);
    chk("async_reset_valid", valid, 0);
    chk("async_reset_timeout", timeout, 0);
    chk("async_reset_period", period, 0);
    chk("async_reset_high", high_time, 0);
    model_reset();
    set_wave(1, 1);
    @(negedge clk);
    steps(3);
    release_and_check_start();
    set_wave(20, 10);
    steps(100);
    chk("period_after_reset", period, 20);
    chk("high_after_reset", high_time, 10);

    steps(5);
    chk("scoreboard_drained", valid_q.size() + rise_q.size() + fall_q.size() + tmo_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
